// File: rtl/inst_cache_if.sv
// inst_cache_if: IF-side fetch handshake and MemCtrl instruction-read port of the instruction cache
interface inst_cache_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  IF_inst_read_valid;
    logic [ADDR_WIDTH-1:0] IF_inst_addr;
    logic                  IF_clear;
    logic                  IF_inst_valid;
    logic [31:0]           IF_inst;
    logic                  MemCtrl_inst_read_valid;
    logic [ADDR_WIDTH-1:0] MemCtrl_inst_addr;
    logic                  MemCtrl_inst_valid;
    logic [31:0]           MemCtrl_inst;

    modport slave (
        input  IF_inst_read_valid, IF_inst_addr, IF_clear, MemCtrl_inst_valid, MemCtrl_inst,
        output IF_inst_valid, IF_inst, MemCtrl_inst_read_valid, MemCtrl_inst_addr
    );

    modport master (
        output IF_inst_read_valid, IF_inst_addr, IF_clear, MemCtrl_inst_valid, MemCtrl_inst,
        input  IF_inst_valid, IF_inst, MemCtrl_inst_read_valid, MemCtrl_inst_addr
    );
endinterface

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped one-word-per-line instruction cache; line storage exists only when ICACHE_EN is defined
module inst_cache #(
    parameter int INDEX_WIDTH = 8,
    parameter int ADDR_WIDTH  = 32
) (
    input logic         clk,
    input logic         rst,
    input logic         rdy,
    inst_cache_if.slave bus
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t      state;
    logic        drop;
    logic        pend;
    logic        hit;
    logic [31:0] hit_word;
    logic        resp;
    logic        unused_offset;

    assign unused_offset = ^bus.IF_inst_addr[1:0];
    assign resp = state == WAIT && bus.MemCtrl_inst_valid;

`ifdef ICACHE_EN
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;
    logic [(1<<INDEX_WIDTH)-1:0] vld;
    logic [TAG_WIDTH-1:0]        tags  [1<<INDEX_WIDTH];
    logic [31:0]                 words [1<<INDEX_WIDTH];
    logic [INDEX_WIDTH-1:0]      req_idx;
    logic [INDEX_WIDTH-1:0]      fill_idx;

    assign req_idx  = bus.IF_inst_addr[INDEX_WIDTH+1:2];
    assign fill_idx = bus.MemCtrl_inst_addr[INDEX_WIDTH+1:2];
    assign hit      = vld[req_idx] && tags[req_idx] == bus.IF_inst_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign hit_word = words[req_idx];

    // Valid bits clear on reset; every response sets its line, even while rdy is low.
    always_ff @(posedge clk)
        if (rst) vld <= '0;
        else if (resp) vld[fill_idx] <= 1'b1;

    // Tag/data are unreset: a line is only read once its valid bit is set.
    always_ff @(posedge clk)
        if (resp) begin
            tags[fill_idx]  <= bus.MemCtrl_inst_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
            words[fill_idx] <= bus.MemCtrl_inst;
        end
`else
    assign hit      = 1'b0;
    assign hit_word = 32'h0;
`endif

    // Control FSM: a response is always consumed; everything else advances only when rdy is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                       <= IDLE;
            drop                        <= 1'b0;
            pend                        <= 1'b0;
            bus.IF_inst_valid           <= 1'b0;
            bus.IF_inst                 <= 32'h0;
            bus.MemCtrl_inst_read_valid <= 1'b0;
            bus.MemCtrl_inst_addr       <= '0;
        end else begin
            bus.IF_inst_valid           <= 1'b0;
            bus.MemCtrl_inst_read_valid <= 1'b0;
            if (resp) begin
                state <= IDLE;
                drop  <= 1'b0;
                if (!drop && !bus.IF_clear) begin
                    bus.IF_inst <= bus.MemCtrl_inst;
                    if (rdy) bus.IF_inst_valid <= 1'b1;
                    else pend <= 1'b1;
                end
            end else if (rdy) begin
                if (state == WAIT) begin
                    if (bus.IF_clear) drop <= 1'b1;
                end else if (pend) begin
                    // The still-held IF request is answered by the word captured during the stall.
                    pend <= 1'b0;
                    if (!bus.IF_clear) bus.IF_inst_valid <= 1'b1;
                end else if (bus.IF_inst_read_valid && !bus.IF_clear) begin
                    if (hit) begin
                        bus.IF_inst       <= hit_word;
                        bus.IF_inst_valid <= 1'b1;
                    end else begin
                        bus.MemCtrl_inst_addr       <= {bus.IF_inst_addr[ADDR_WIDTH-1:2], 2'b00};
                        bus.MemCtrl_inst_read_valid <= 1'b1;
                        state                       <= WAIT;
                    end
                end
            end
        end
    end
endmodule
